// File: rtl/stopwatch_ctrl.sv
// Pushbutton/switch front end and mode sequencer driving the stopwatch datapath.
// Raw button edge to output pulse: DEBOUNCE_CYCLES+3 cycles; no backpressure, pulses are single-cycle and registered.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ALARM_CYCLES    = 300_000_000,
  parameter int CNT_W           = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_rst,
  input  logic       btn_inc,
  input  logic       btn_min,
  input  logic       sw_up,
  input  logic       sw_prog,
  input  logic       zero,
  output logic       s,
  output logic       p,
  output logic       u,
  output logic       sw_rst,
  output logic       inc,
  output logic       min,
  output logic       beep,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    PAUSED  = 3'd2,
    PROGRAM = 3'd3,
    ALARM   = 3'd4
  } state_t;

  localparam int NB    = 4;
  localparam int B_SS  = 0;
  localparam int B_RST = 1;
  localparam int B_INC = 2;
  localparam int B_MIN = 3;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AL_LAST = CNT_W'(ALARM_CYCLES - 1);

  logic [NB-1:0]    btn_s1, btn_s2, btn_deb, btn_deb_q, pls;
  logic [CNT_W-1:0] db_cnt [NB];
  logic             up_s1, up_s2, prog_s1, prog_s2;
  logic             zero_q, zero_rise;

  // The up-switch synchronizer resets to 1 so u holds its reset value until the real switch arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      up_s1     <= 1'b1;
      up_s2     <= 1'b1;
      prog_s1   <= 1'b0;
      prog_s2   <= 1'b0;
      zero_q    <= 1'b0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1    <= {btn_min, btn_inc, btn_rst, btn_ss};
      btn_s2    <= btn_s1;
      btn_deb_q <= btn_deb;
      up_s1     <= sw_up;
      up_s2     <= up_s1;
      prog_s1   <= sw_prog;
      prog_s2   <= prog_s1;
      zero_q    <= zero;
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] == btn_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]  <= '0;
          btn_deb[i] <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pls       = btn_deb & ~btn_deb_q;
  assign zero_rise = zero & ~zero_q;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] al_cnt, al_cnt_nxt;
  logic             u_nxt, s_nxt, sw_rst_nxt, inc_nxt, min_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      al_cnt <= '0;
      u      <= 1'b1;
      s      <= 1'b0;
      sw_rst <= 1'b0;
      inc    <= 1'b0;
      min    <= 1'b0;
    end else begin
      state  <= state_nxt;
      al_cnt <= al_cnt_nxt;
      u      <= u_nxt;
      s      <= s_nxt;
      sw_rst <= sw_rst_nxt;
      inc    <= inc_nxt;
      min    <= min_nxt;
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    al_cnt_nxt = '0;
    u_nxt      = u;
    s_nxt      = 1'b0;
    sw_rst_nxt = 1'b0;
    inc_nxt    = 1'b0;
    min_nxt    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt  = IDLE;
        u_nxt      = up_s2;
        sw_rst_nxt = pls[B_RST];
        if (prog_s2) begin
          state_nxt = PROGRAM;
        end else if (pls[B_SS] && !pls[B_RST]) begin
          state_nxt = RUNNING;
          s_nxt     = 1'b1;
        end
      end
      RUNNING: begin
        state_nxt = RUNNING;
        // Countdown expiry outranks both buttons; the s pulse halts the datapath.
        if (!u && zero_rise) begin
          state_nxt = ALARM;
          s_nxt     = 1'b1;
        end else if (pls[B_RST]) begin
          sw_rst_nxt = 1'b1;
        end else if (pls[B_SS]) begin
          state_nxt = PAUSED;
          s_nxt     = 1'b1;
        end
      end
      PAUSED: begin
        state_nxt = PAUSED;
        u_nxt     = up_s2;
        if (pls[B_RST]) begin
          state_nxt  = IDLE;
          sw_rst_nxt = 1'b1;
        end else if (pls[B_SS]) begin
          state_nxt = RUNNING;
          s_nxt     = 1'b1;
        end
      end
      PROGRAM: begin
        state_nxt  = prog_s2 ? PROGRAM : IDLE;
        inc_nxt    = pls[B_INC];
        min_nxt    = pls[B_MIN];
        sw_rst_nxt = pls[B_RST];
      end
      ALARM: begin
        if ((|pls) || al_cnt == AL_LAST) begin
          state_nxt  = IDLE;
          sw_rst_nxt = 1'b1;
        end else begin
          state_nxt  = ALARM;
          al_cnt_nxt = al_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mode = state;
  assign p    = (state == PROGRAM);
  assign beep = (state == ALARM);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized buttons/switches against a reference model.
module tb_stopwatch_ctrl;

  localparam int DB = 4;
  localparam int AL = 20;

  logic       clk = 1'b0;
  logic       rst, btn_ss, btn_rst, btn_inc, btn_min, sw_up, sw_prog, zero;
  logic       s, p, u, sw_rst, inc, min, beep;
  logic [2:0] mode;

  int n_vec = 0;
  int n_err = 0;
  int cnt_s, cnt_sw_rst, cnt_inc, cnt_min;

  // Reference model: raw sample history, accepted button levels, mode as an integer.
  logic [3:0] h_btn [$];
  logic [1:0] h_sw  [$];
  logic [3:0] m_deb, m_rose;
  int         m_mode, m_age;
  logic       m_u, m_s, m_sw_rst, m_inc, m_min, m_zero_prev;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .ALARM_CYCLES(AL), .CNT_W(29)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_rst(btn_rst), .btn_inc(btn_inc),
    .btn_min(btn_min), .sw_up(sw_up), .sw_prog(sw_prog), .zero(zero),
    .s(s), .p(p), .u(u), .sw_rst(sw_rst), .inc(inc), .min(min), .beep(beep), .mode(mode)
  );

  task automatic m_reset();
    h_btn.delete();
    h_sw.delete();
    repeat (6) begin
      h_btn.push_back(4'b0000);
      h_sw.push_back(2'b01);
    end
    m_deb = '0; m_rose = '0; m_mode = 0; m_age = 0; m_u = 1'b1;
    m_s = 1'b0; m_sw_rst = 1'b0; m_inc = 1'b0; m_min = 1'b0; m_zero_prev = 1'b0;
  endtask

  // A button is accepted once its synchronized (two-sample-old) value has
  // disagreed with the accepted level for DB consecutive samples.
  task automatic model_edge();
    logic [3:0] pl, flip;
    logic       up_q, prog_q, zrise, ss, rs, ic, mn;
    int         n;
    if (rst) begin
      m_reset();
      return;
    end
    n  = h_btn.size();
    pl = m_rose;
    {prog_q, up_q} = h_sw[n-2];
    for (int b = 0; b < 4; b++) begin
      flip[b] = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (h_btn[n-k][b] == m_deb[b]) flip[b] = 1'b0;
    end
    m_rose = flip & ~m_deb;
    m_deb  = m_deb ^ flip;
    h_btn.push_back({btn_min, btn_inc, btn_rst, btn_ss});
    h_sw.push_back({sw_prog, sw_up});
    if (h_btn.size() > 8) begin
      void'(h_btn.pop_front());
      void'(h_sw.pop_front());
    end
    zrise = zero & ~m_zero_prev;
    m_zero_prev = zero;
    {mn, ic, rs, ss} = pl;
    m_s = 1'b0; m_sw_rst = 1'b0; m_inc = 1'b0; m_min = 1'b0;
    case (m_mode)
      0: begin
        m_u = up_q;
        m_sw_rst = rs;
        if (prog_q) m_mode = 3;
        else if (ss && !rs) begin m_mode = 1; m_s = 1'b1; end
      end
      1: begin
        if (!m_u && zrise) begin m_mode = 4; m_s = 1'b1; m_age = 0; end
        else if (rs) m_sw_rst = 1'b1;
        else if (ss) begin m_mode = 2; m_s = 1'b1; end
      end
      2: begin
        m_u = up_q;
        if (rs) begin m_mode = 0; m_sw_rst = 1'b1; end
        else if (ss) begin m_mode = 1; m_s = 1'b1; end
      end
      3: begin
        m_inc = ic; m_min = mn; m_sw_rst = rs;
        if (!prog_q) m_mode = 0;
      end
      default: begin
        if (pl != 4'b0 || m_age == AL - 1) begin m_mode = 0; m_sw_rst = 1'b1; end
        else m_age++;
      end
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (s === 1'b1) cnt_s++;
    if (sw_rst === 1'b1) cnt_sw_rst++;
    if (inc === 1'b1) cnt_inc++;
    if (min === 1'b1) cnt_min++;
  endtask

  task automatic clr_cnt();
    cnt_s = 0; cnt_sw_rst = 0; cnt_inc = 0; cnt_min = 0;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_ss = v;
      1: btn_rst = v;
      2: btn_inc = v;
      default: btn_min = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (DB + 4) tick();
    set_btn(b, 1'b0);
    repeat (DB + 4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if ({mode, p, beep, s, sw_rst, inc, min} !== 9'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 000000000", {mode, p, beep, s, sw_rst, inc, min}); end
    n_vec++; if (u !== 1'b1) begin n_err++; $display("FAIL reset_u: got %b want 1", u); end
    rst = 1'b0;
    repeat (4) tick();
    n_vec++; if (mode !== 3'd0 || u !== 1'b1) begin
      n_err++; $display("FAIL reset_release: mode %0d u %b want 0 1", mode, u); end
  endtask

  task automatic test_debounce();
    int first;
    clr_cnt();
    btn_ss = 1'b1;
    repeat (DB - 1) tick();
    btn_ss = 1'b0;
    repeat (12) tick();
    n_vec++; if (cnt_s != 0 || mode !== 3'd0) begin
      n_err++; $display("FAIL debounce_glitch: s pulses %0d mode %0d want 0 0", cnt_s, mode); end
    clr_cnt();
    first = -1;
    btn_ss = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (s === 1'b1 && first < 0) first = i;
    end
    btn_ss = 1'b0;
    repeat (10) tick();
    n_vec++; if (cnt_s != 1) begin n_err++; $display("FAIL debounce_count: got %0d want 1", cnt_s); end
    n_vec++; if (first != DB + 3) begin n_err++; $display("FAIL debounce_latency: got %0d want %0d", first, DB + 3); end
    n_vec++; if (mode !== 3'd1) begin n_err++; $display("FAIL debounce_mode: got %0d want 1", mode); end
  endtask

  task automatic test_run_pause();
    clr_cnt();
    sw_up = 1'b0;
    repeat (6) tick();
    n_vec++; if (u !== 1'b1) begin n_err++; $display("FAIL run_u_hold: got %b want 1", u); end
    sw_up = 1'b1;
    repeat (3) tick();
    press(0);
    n_vec++; if (mode !== 3'd2 || cnt_s != 1) begin
      n_err++; $display("FAIL pause: mode %0d s %0d want 2 1", mode, cnt_s); end
    press(1);
    n_vec++; if (mode !== 3'd0 || cnt_sw_rst != 1) begin
      n_err++; $display("FAIL pause_rst: mode %0d sw_rst %0d want 0 1", mode, cnt_sw_rst); end
    clr_cnt();
    press(0);
    n_vec++; if (mode !== 3'd1) begin n_err++; $display("FAIL seq_run: got %0d want 1", mode); end
    press(0);
    n_vec++; if (mode !== 3'd2) begin n_err++; $display("FAIL seq_pause: got %0d want 2", mode); end
    press(1);
    n_vec++; if (mode !== 3'd0 || cnt_s != 2 || cnt_sw_rst != 1) begin
      n_err++; $display("FAIL seq_idle: mode %0d s %0d sw_rst %0d want 0 2 1", mode, cnt_s, cnt_sw_rst); end
  endtask

  task automatic test_program();
    clr_cnt();
    sw_prog = 1'b1;
    repeat (4) tick();
    n_vec++; if (mode !== 3'd3 || p !== 1'b1) begin
      n_err++; $display("FAIL prog_enter: mode %0d p %b want 3 1", mode, p); end
    repeat (5) press(2);
    n_vec++; if (cnt_inc != 5) begin n_err++; $display("FAIL prog_inc: got %0d want 5", cnt_inc); end
    press(3);
    n_vec++; if (cnt_min != 1) begin n_err++; $display("FAIL prog_min: got %0d want 1", cnt_min); end
    press(0);
    n_vec++; if (cnt_s != 0 || mode !== 3'd3) begin
      n_err++; $display("FAIL prog_ss: s %0d mode %0d want 0 3", cnt_s, mode); end
    sw_prog = 1'b0;
    repeat (4) tick();
    n_vec++; if (mode !== 3'd0 || p !== 1'b0) begin
      n_err++; $display("FAIL prog_exit: mode %0d p %b want 0 0", mode, p); end
  endtask

  task automatic run_alarm(input int inc_at, input int exp_exit);
    int   exit_at;
    logic sr;
    sw_up = 1'b0;
    repeat (4) tick();
    n_vec++; if (u !== 1'b0) begin n_err++; $display("FAIL alarm_u: got %b want 0", u); end
    press(0);
    clr_cnt();
    zero = 1'b1;
    tick();
    n_vec++; if (mode !== 3'd4 || beep !== 1'b1 || s !== 1'b1) begin
      n_err++; $display("FAIL alarm_enter: mode %0d beep %b s %b want 4 1 1", mode, beep, s); end
    exit_at = -1;
    for (int i = 1; i <= AL + 10; i++) begin
      if (inc_at > 0 && i == inc_at + 1) btn_inc = 1'b1;
      tick();
      if (mode !== 3'd4) begin
        exit_at = i;
        break;
      end
    end
    sr = sw_rst;
    btn_inc = 1'b0;
    zero = 1'b0;
    repeat (10) tick();
    n_vec++; if (exit_at != exp_exit) begin n_err++; $display("FAIL alarm_len: got %0d want %0d", exit_at, exp_exit); end
    n_vec++; if (sr !== 1'b1 || cnt_sw_rst != 1) begin
      n_err++; $display("FAIL alarm_sw_rst: at_exit %b count %0d want 1 1", sr, cnt_sw_rst); end
    n_vec++; if (cnt_s != 1 || cnt_inc != 0 || mode !== 3'd0 || beep !== 1'b0) begin
      n_err++; $display("FAIL alarm_after: s %0d inc %0d mode %0d beep %b want 1 0 0 0", cnt_s, cnt_inc, mode, beep); end
  endtask

  task automatic test_alarm();
    run_alarm(0, AL);
    run_alarm(5, 5 + DB + 3);
    sw_up = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_collision();
    press(0);
    n_vec++; if (mode !== 3'd1) begin n_err++; $display("FAIL coll_setup: got %0d want 1", mode); end
    clr_cnt();
    btn_ss = 1'b1; btn_rst = 1'b1;
    repeat (DB + 4) tick();
    btn_ss = 1'b0; btn_rst = 1'b0;
    repeat (DB + 4) tick();
    n_vec++; if (cnt_s != 0 || cnt_sw_rst != 1 || mode !== 3'd1) begin
      n_err++; $display("FAIL collision: s %0d sw_rst %0d mode %0d want 0 1 1", cnt_s, cnt_sw_rst, mode); end
  endtask

  task automatic test_reset_mid();
    clr_cnt();
    btn_ss = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_vec++; if ({mode, p, beep, s, sw_rst, inc, min} !== 9'b0 || u !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_db: outs %b u %b want 000000000 1", {mode, p, beep, s, sw_rst, inc, min}, u); end
    btn_ss = 1'b0;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    n_vec++; if (cnt_s != 0 || mode !== 3'd0) begin
      n_err++; $display("FAIL rst_mid_db_after: s %0d mode %0d want 0 0", cnt_s, mode); end
    sw_up = 1'b0;
    repeat (4) tick();
    press(0);
    zero = 1'b1;
    tick();
    repeat (5) tick();
    n_vec++; if (mode !== 3'd4) begin n_err++; $display("FAIL rst_mid_al_setup: got %0d want 4", mode); end
    rst = 1'b1;
    tick();
    n_vec++; if ({mode, p, beep, s, sw_rst, inc, min} !== 9'b0 || u !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_al: outs %b u %b want 000000000 1", {mode, p, beep, s, sw_rst, inc, min}, u); end
    zero = 1'b0;
    sw_up = 1'b1;
    tick();
    rst = 1'b0;
    clr_cnt();
    repeat (25) tick();
    n_vec++; if (cnt_s != 0 || cnt_sw_rst != 0 || mode !== 3'd0 || u !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_al_after: s %0d sw_rst %0d mode %0d u %b want 0 0 0 1", cnt_s, cnt_sw_rst, mode, u); end
  endtask

  task automatic test_random();
    int         tmr [4];
    logic [3:0] bv;
    logic [9:0] got, want;
    bv = 4'b0000;
    for (int b = 0; b < 4; b++) tmr[b] = int'($urandom_range(1, 10));
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (tmr[b] == 0) begin
          bv[b] = ~bv[b];
          tmr[b] = (b == 1) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
        end else begin
          tmr[b]--;
        end
      end
      {btn_min, btn_inc, btn_rst, btn_ss} = bv;
      if ($urandom_range(0, 19) == 0) sw_up = ~sw_up;
      if ($urandom_range(0, 79) == 0) sw_prog = ~sw_prog;
      if ($urandom_range(0, 5) == 0) zero = ~zero;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      want = {3'(m_mode), m_mode == 3, m_u, m_mode == 4, m_s, m_sw_rst, m_inc, m_min};
      got  = {mode, p, u, beep, s, sw_rst, inc, min};
      n_vec++; if (got !== want) begin
        n_err++; $display("FAIL random c=%0d {mode,p,u,beep,s,sw_rst,inc,min}: got %b want %b", c, got, want); end
    end
    rst = 1'b0;
    {btn_min, btn_inc, btn_rst, btn_ss} = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; btn_ss = 1'b0; btn_rst = 1'b0; btn_inc = 1'b0; btn_min = 1'b0;
    sw_up = 1'b1; sw_prog = 1'b0; zero = 1'b0;
    m_reset();
    clr_cnt();
    test_reset();
    test_debounce();
    test_run_pause();
    test_program();
    test_alarm();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
